mips_multicycle_ctrl: RTL

Multi-cycle control FSM for the Mini-MIPS datapath inside cpu. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each step drives the mux selects and enables for the single shared memory, the IR, the register file, the ALU and the PC. It waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/mips_multicycle_ctrl_if.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller bus; master=controller drives selects/enables/status, reads opcode/zero/mem_ready
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] opcode;
  logic zero;
  logic mem_ready;
  logic pc_write;
  logic pc_write_cond;
  logic iord;
  logic mem_read;
  logic mem_write;
  logic ir_write;
  logic reg_dst;
  logic mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0] state;
  modport master(
    input opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, instr_count, state
  );
  modport slave(
    output opcode, zero, mem_ready,
    input pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, instr_count, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle Mini-MIPS control FSM; ports clock, reset (async high), bus (master: datapath controls, illegal_op, instr_count, state)
module mips_multicycle_ctrl #(parameter int CNT_W = 32) (
  input logic clock,
  input logic reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
    OP_J = 6'b000010, OP_ADDI = 6'b001000;
  logic [3:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic retire, illegal, run;
  logic [5:0] op;
  assign op = bus.opcode;
  always_comb begin
    state_d = FETCH;
    retire = 1'b0;
    illegal = 1'b0;
    case (state_q)
      FETCH: state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        state_d = op == OP_R ? EXEC : (op == OP_LW || op == OP_SW) ? MEMADR : op == OP_BEQ ? BRANCH :
                  op == OP_J ? JUMP : op == OP_ADDI ? ADDIEX : FETCH;
        illegal = state_d == FETCH;
      end
      MEMADR: state_d = op == OP_SW ? MEMWR : MEMRD;
      MEMRD: state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        state_d = bus.mem_ready ? FETCH : MEMWR;
        retire = bus.mem_ready;
      end
      EXEC: state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: retire = 1'b1;
      default: state_d = FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign run = ~reset;
  assign bus.mem_read = run & (state_q == FETCH || state_q == MEMRD);
  assign bus.mem_write = run & (state_q == MEMWR);
  assign bus.iord = run & (state_q == MEMRD || state_q == MEMWR);
  assign bus.ir_write = run & (state_q == FETCH) & bus.mem_ready;
  assign bus.pc_write = run & ((state_q == FETCH & bus.mem_ready) | (state_q == JUMP));
  assign bus.pc_write_cond = run & (state_q == BRANCH);
  assign bus.reg_dst = run & (state_q == ALUWB);
  assign bus.mem_to_reg = run & (state_q == MEMWB);
  assign bus.reg_write = run & (state_q == MEMWB || state_q == ALUWB || state_q == ADDIWB);
  assign bus.alu_src_a = run & (state_q == MEMADR || state_q == EXEC || state_q == BRANCH || state_q == ADDIEX);
  assign bus.alu_src_b = !run ? 2'd0 : state_q == FETCH ? 2'd1 : state_q == DECODE ? 2'd3 :
                         (state_q == MEMADR || state_q == ADDIEX) ? 2'd2 : 2'd0;
  assign bus.alu_op = !run ? 2'd0 : state_q == BRANCH ? 2'd1 : state_q == EXEC ? 2'd2 : 2'd0;
  assign bus.pc_src = !run ? 2'd0 : state_q == BRANCH ? 2'd1 : state_q == JUMP ? 2'd2 : 2'd0;
  assign bus.illegal_op = run & illegal;
  assign bus.instr_count = cnt_q;
  assign bus.state = state_q;
endmodule
